fpu_io_sequencer: RTL and testbench
===================================

# fpu_io_sequencer

Front-end controller for the 16-bit FPU core on the 12-pin chip interface. It assembles half-precision operands from tagged byte beats and accepts an opcode beat. It then issues one operation to the FPU core, waits for completion, and serializes the 16-bit result and flags back out as tagged byte beats. It sits between the top-level `io_in`/`io_out` pins and the FPU core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: number of WAIT cycles before abort. Used only when `FPU_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_tag` in 2: input beat type. 00 none, 01 operand A byte, 10 operand B byte, 11 command.
- `in_val` in 8: input beat payload.
- `ready` out 1: high when in IDLE and accepting beats.
- `out_tag` out 2: output beat type. 00 none, 01 result high byte, 10 result low byte, 11 status.
- `out_val` out 8: output beat payload.
- `fpu_a`, `fpu_b` out 16: operands to the core.
- `fpu_op` out 4: opcode to the core (0010 = subtract; other codes are decoded by the core).
- `fpu_start` out 1: one-cycle issue pulse.
- `fpu_abort` out 1: one-cycle abort pulse.
- `fpu_done` in 1: core completion strobe.
- `fpu_result` in 16: core result, valid with `fpu_done`.
- `fpu_flags` in 5: {NV, DZ, OF, UF, NX}, valid with `fpu_done`.

## Operation
- States: IDLE → ISSUE → WAIT → OUT_HI → OUT_LO → OUT_ST → IDLE. With the macro, WAIT can instead go to OUT_ERR → IDLE.
- Operand loading in IDLE:
  - Tag 01 shifts the byte into A: A ← {A[7:0], in_val}. Tag 10 does the same for B.
  - The first byte of a pair therefore lands in the high byte: beats 0x4E then 0x54 give 16'h4E54.
  - Extra bytes simply shift. The last two bytes win; there is no byte pointer.
  - A and B persist across operations, so a new command reuses them.
- Command: tag 11 in IDLE latches `fpu_op` ← in_val[3:0] (in_val[7:4] ignored) and moves to ISSUE.
- Tag 00 has no effect.
- Beats arriving outside IDLE (`ready` low) are dropped. Operand registers do not change while busy.
- ISSUE: `fpu_start` = 1 for exactly this cycle. `fpu_a`, `fpu_b` and `fpu_op` are held stable from ISSUE until return to IDLE.
- WAIT: on `fpu_done` = 1, capture `fpu_result` and `fpu_flags`, then go to OUT_HI.
- `fpu_done` is ignored in every state except WAIT.
- Output beats:
  - OUT_HI emits (01, result[15:8]).
  - OUT_LO emits (10, result[7:0]).
  - OUT_ST emits (11, {3'b000, flags}).
  - Every other state emits (00, 8'h00).
- Reset values: `ready` 0, `out_tag` 00, `out_val` 00, `fpu_start` 0, `fpu_abort` 0. `fpu_a`, `fpu_b`, `fpu_op` 0. State IDLE.
- Reset dominates every input, including tag 11 held during reset. Reset mid-operation returns to IDLE with no output beats and no abort pulse.

## Timing
- All outputs are registered.
- `ready` is high the first cycle after `reset` is deasserted.
- A command sampled at edge N gives:
  - `fpu_start` high in cycle N+1;
  - WAIT entered from edge N+2.
- The core must raise `fpu_done` no earlier than the cycle after `fpu_start`. `fpu_done` sampled at edge M gives:
  - output beats in cycles M+1, M+2, M+3;
  - `ready` high in cycle M+4.
- Minimum command-to-next-ready time: 6 cycles.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments on each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `fpu_done`, the block pulses `fpu_abort` for one cycle and enters OUT_ERR.
  - OUT_ERR emits the single beat (11, 8'hFF), then returns to IDLE.
  - A late `fpu_done` is ignored.
  - `fpu_done` in the same cycle the count reaches the limit wins: normal completion, no abort.
- `FPU_SEQ_TIMEOUT_EN` undefined: WAIT has no bound, `fpu_abort` is tied 0, and the counter is not built.

## Structure
- Package `fpu_seq_pkg` holds:
  - the state enum;
  - in/out tag constants (`TAG_NONE`, `TAG_A`/`TAG_HI`, `TAG_B`/`TAG_LO`, `TAG_CMD`/`TAG_ST`);
  - `ERR_BYTE` = 8'hFF;
  - the flag bit indices.
- One sub-module, `fpu_seq_watchdog` (counter, clear, expire), instantiated only under the macro.

## Test plan
- Reset held with tag 11 and in_val 0x4E → no `fpu_start`. `ready` = 0 during reset and = 1 in the first cycle after release.
- A beats 0x4E, 0x54; B beats 0x4E, 0x54; command 0x02 → `fpu_a` = `fpu_b` = 16'h4E54, `fpu_op` = 2, one-cycle `fpu_start`. A model core returns 16'h0000 with flags 0 after 3 cycles → beats (01,00), (10,00), (11,00), then `ready` = 1.
- Three A beats 0x11, 0x22, 0x33 → `fpu_a` = 16'h2233. A second command 0x03 with no reload → same operands reissued.
- Operand and command beats sent while `ready` = 0 → dropped; `fpu_a`/`fpu_b` unchanged; exactly one `fpu_start`.
- Reset asserted in WAIT → IDLE next cycle, no output beats. A subsequent `fpu_done` is ignored.
- With `FPU_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, the core never responds → `fpu_abort` pulse after 8 WAIT cycles, beat (11, FF), then `ready` = 1. The same test with `fpu_done` on the 8th cycle → normal result beats and no abort.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU I/O sequencer: FSM states, beat tags,
// flag bit positions and the output beat payload.
package fpu_seq_pkg;

  localparam int unsigned TAG_W   = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned OPND_W  = 16;
  localparam int unsigned OP_W    = 4;

  // Flag bit positions inside fpu_flags / the status beat
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAGS_W = FLAG_NV + 1;

  localparam logic [TAG_W-1:0] TAG_NONE = 2'b00;
  localparam logic [TAG_W-1:0] TAG_A    = 2'b01;
  localparam logic [TAG_W-1:0] TAG_B    = 2'b10;
  localparam logic [TAG_W-1:0] TAG_CMD  = 2'b11;
  localparam logic [TAG_W-1:0] TAG_HI   = 2'b01;
  localparam logic [TAG_W-1:0] TAG_LO   = 2'b10;
  localparam logic [TAG_W-1:0] TAG_ST   = 2'b11;

  localparam logic [BYTE_W-1:0] ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT_HI,
    ST_OUT_LO,
    ST_OUT_ST,
    ST_OUT_ERR
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [BYTE_W-1:0] val;
  } beat_t;

endpackage

// File: rtl/fpu_io_sequencer_if.sv
// Pin-side beat bus and FPU-core handshake seen by the sequencer.
// master: the sequencer; slave: the pins/core environment around it.
interface fpu_io_sequencer_if;
  import fpu_seq_pkg::*;

  logic [TAG_W-1:0]   in_tag;
  logic [BYTE_W-1:0]  in_val;
  logic               ready;
  logic [TAG_W-1:0]   out_tag;
  logic [BYTE_W-1:0]  out_val;
  logic [OPND_W-1:0]  fpu_a;
  logic [OPND_W-1:0]  fpu_b;
  logic [OP_W-1:0]    fpu_op;
  logic               fpu_start;
  logic               fpu_abort;
  logic               fpu_done;
  logic [OPND_W-1:0]  fpu_result;
  logic [FLAGS_W-1:0] fpu_flags;

  modport master (
    input  in_tag, in_val, fpu_done, fpu_result, fpu_flags,
    output ready, out_tag, out_val, fpu_a, fpu_b, fpu_op, fpu_start, fpu_abort
  );

  modport slave (
    output in_tag, in_val, fpu_done, fpu_result, fpu_flags,
    input  ready, out_tag, out_val, fpu_a, fpu_b, fpu_op, fpu_start, fpu_abort
  );
endinterface

// File: rtl/fpu_seq_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles and flags expiry on the LIMIT-th one.
// Only instantiated when FPU_SEQ_TIMEOUT_EN is defined.
module fpu_seq_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expires during the cycle whose edge would complete the LIMIT-th WAIT cycle
  assign expire_c = count_en && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fpu_io_sequencer.sv
// Byte-beat front end for the 16-bit FPU core: loads operands, issues one op,
// serializes result and flags. Define FPU_SEQ_TIMEOUT_EN to bound the WAIT state.
module fpu_io_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  fpu_io_sequencer_if.master  bus
);

  state_t               state_q, state_n;
  logic                 ready_q, start_q;
  beat_t                beat_q, beat_n;
  logic [OPND_W-1:0]    a_q, a_n, b_q, b_n, res_q, res_n;
  logic [OP_W-1:0]      op_q, op_n;
  logic [FLAGS_W-1:0]   flags_q, flags_n;
  logic                 accept_c, done_c, timeout_c;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  logic abort_q;

  fpu_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_q != ST_WAIT),
    .count_en (state_q == ST_WAIT),
    .expire_c (timeout_c)
  );

  always_ff @(posedge clock) begin
    if (reset) abort_q <= 1'b0;
    else       abort_q <= (state_n == ST_OUT_ERR);
  end

  assign bus.fpu_abort = abort_q;
`else
  assign timeout_c     = 1'b0;
  assign bus.fpu_abort = 1'b0;
`endif

  // ready_q doubles as the accept qualifier, so the first post-reset edge drops beats
  assign accept_c = ready_q;
  assign done_c   = (state_q == ST_WAIT) && bus.fpu_done;

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    res_n   = res_q;
    flags_n = flags_q;
    beat_n  = '{tag: TAG_NONE, val: 8'h00};

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (bus.in_tag)
            TAG_A:   a_n = {a_q[BYTE_W-1:0], bus.in_val};
            TAG_B:   b_n = {b_q[BYTE_W-1:0], bus.in_val};
            TAG_CMD: begin
              op_n    = bus.in_val[OP_W-1:0];
              state_n = ST_ISSUE;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (done_c) begin
          res_n   = bus.fpu_result;
          flags_n = bus.fpu_flags;
          state_n = ST_OUT_HI;
        end else if (timeout_c) begin
          state_n = ST_OUT_ERR;
        end
      end
      ST_OUT_HI: state_n = ST_OUT_LO;
      ST_OUT_LO: state_n = ST_OUT_ST;
      ST_OUT_ST: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // Output beat for the state about to be entered, so it registers alongside it
    case (state_n)
      ST_OUT_HI:  beat_n = '{tag: TAG_HI, val: res_n[OPND_W-1:BYTE_W]};
      ST_OUT_LO:  beat_n = '{tag: TAG_LO, val: res_n[BYTE_W-1:0]};
      ST_OUT_ST:  beat_n = '{tag: TAG_ST, val: {3'b000, flags_n}};
      ST_OUT_ERR: beat_n = '{tag: TAG_ST, val: ERR_BYTE};
      default:    ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
      start_q <= 1'b0;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      ready_q <= (state_n == ST_IDLE);
      start_q <= (state_n == ST_ISSUE);
      beat_q  <= beat_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      res_q   <= res_n;
      flags_q <= flags_n;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.fpu_start = start_q;
  assign bus.out_tag   = beat_q.tag;
  assign bus.out_val   = beat_q.val;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.fpu_op    = op_q;

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Directed bench for fpu_io_sequencer: operand-load vector table plus
// hand-written operation, reset-abort and (with FPU_SEQ_TIMEOUT_EN) timeout sequences.
module tb_fpu_io_sequencer;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_cnt = 0;
  int   abort_cnt = 0;
  int   beat_cnt  = 0;

  fpu_io_sequencer_if bus ();

  fpu_io_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event counters sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (bus.fpu_start === 1'b1) start_cnt++;
    if (bus.fpu_abort === 1'b1) abort_cnt++;
    if (bus.out_tag !== 2'b00 && reset === 1'b0) beat_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "bench timed out");
  end

  typedef struct {
    logic [1:0]  tag;
    logic [7:0]  val;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tag, input logic [7:0] val);
    bus.in_tag = tag;
    bus.in_val = val;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [1:0] tag, input logic [7:0] val);
    check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    check({name, "_val"}, 32'(bus.out_val), 32'(val));
  endtask

  task automatic apply_vec(input int i);
    drive(vecs[i].tag, vecs[i].val);
    tick();
    drive(2'b00, 8'h00);
    check($sformatf("vec%0d_a", i), 32'(bus.fpu_a), 32'(vecs[i].exp_a));
    check($sformatf("vec%0d_b", i), 32'(bus.fpu_b), 32'(vecs[i].exp_b));
    check($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'h1);
  endtask

  // One full operation; lat = WAIT cycles up to and including the done cycle
  task automatic run_op(input string name, input logic [7:0] cmd, input logic [3:0] exp_op,
                        input logic [15:0] exp_a, input logic [15:0] exp_b, input int lat,
                        input logic [15:0] res, input logic [4:0] flg, input bit junk);
    int s0;
    s0 = start_cnt;
    drive(2'b11, cmd);
    tick();
    check({name, "_start"}, 32'(bus.fpu_start), 32'h1);
    check({name, "_ready_busy"}, 32'(bus.ready), 32'h0);
    check({name, "_op"}, 32'(bus.fpu_op), 32'(exp_op));
    check({name, "_a"}, 32'(bus.fpu_a), 32'(exp_a));
    check({name, "_b"}, 32'(bus.fpu_b), 32'(exp_b));
    if (junk) drive(2'b01, 8'hEE); else drive(2'b00, 8'h00);
    tick();
    check({name, "_start_pulse"}, 32'(bus.fpu_start), 32'h0);
    for (int i = 1; i < lat; i++) begin
      if (junk) drive((i == 1) ? 2'b10 : 2'b11, (i == 1) ? 8'hDD : 8'h07);
      tick();
      check({name, "_wait_tag"}, 32'(bus.out_tag), 32'h0);
    end
    bus.fpu_done   = 1'b1;
    bus.fpu_result = res;
    bus.fpu_flags  = flg;
    tick();
    bus.fpu_done   = 1'b0;
    bus.fpu_result = 16'hDEAD;
    bus.fpu_flags  = 5'h1F;
    if (junk) drive(2'b01, 8'h99);
    check_beat({name, "_hi"}, 2'b01, res[15:8]);
    tick();
    check_beat({name, "_lo"}, 2'b10, res[7:0]);
    tick();
    check_beat({name, "_st"}, 2'b11, {3'b000, flg});
    tick();
    drive(2'b00, 8'h00);
    check({name, "_ready_after"}, 32'(bus.ready), 32'h1);
    check_beat({name, "_idle"}, 2'b00, 8'h00);
    check({name, "_a_held"}, 32'(bus.fpu_a), 32'(exp_a));
    check({name, "_b_held"}, 32'(bus.fpu_b), 32'(exp_b));
    check({name, "_op_held"}, 32'(bus.fpu_op), 32'(exp_op));
    check({name, "_one_start"}, 32'(start_cnt - s0), 32'h1);
  endtask

  initial begin
    int b0;
    vecs[0] = '{2'b01, 8'h4E, 16'h004E, 16'h0000};
    vecs[1] = '{2'b01, 8'h54, 16'h4E54, 16'h0000};
    vecs[2] = '{2'b10, 8'h4E, 16'h4E54, 16'h004E};
    vecs[3] = '{2'b10, 8'h54, 16'h4E54, 16'h4E54};
    vecs[4] = '{2'b00, 8'hFF, 16'h4E54, 16'h4E54};
    vecs[5] = '{2'b01, 8'h11, 16'h5411, 16'h4E54};
    vecs[6] = '{2'b01, 8'h22, 16'h1122, 16'h4E54};
    vecs[7] = '{2'b01, 8'h33, 16'h2233, 16'h4E54};

    reset          = 1'b1;
    bus.fpu_done   = 1'b0;
    bus.fpu_result = 16'h0000;
    bus.fpu_flags  = 5'h00;
    drive(2'b11, 8'h4E);

    // Reset held with a command beat on the pins
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(bus.ready), 32'h0);
      check("rst_start", 32'(bus.fpu_start), 32'h0);
      check_beat("rst_beat", 2'b00, 8'h00);
      check("rst_a", 32'(bus.fpu_a), 32'h0);
      check("rst_op", 32'(bus.fpu_op), 32'h0);
    end
    reset = 1'b0;
    tick();
    drive(2'b00, 8'h00);
    check("post_rst_ready", 32'(bus.ready), 32'h1);
    check("post_rst_start", 32'(bus.fpu_start), 32'h0);
    tick();
    check("post_rst_start2", 32'(bus.fpu_start), 32'h0);
    check("post_rst_start_cnt", 32'(start_cnt), 32'h0);

    for (int i = 0; i < 5; i++) apply_vec(i);
    run_op("op_sub", 8'h02, 4'h2, 16'h4E54, 16'h4E54, 3, 16'h0000, 5'h00, 1'b0);

    for (int i = 5; i < 8; i++) apply_vec(i);
    run_op("op_reuse", 8'hA3, 4'h3, 16'h2233, 16'h4E54, 3, 16'hC3A5, 5'b10101, 1'b1);
    run_op("op_fast", 8'h05, 4'h5, 16'h2233, 16'h4E54, 1, 16'h7C00, 5'b01000, 1'b0);

    // Reset while waiting for the core
    b0 = beat_cnt;
    drive(2'b11, 8'h02);
    tick();
    drive(2'b00, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrst_ready_in_reset", 32'(bus.ready), 32'h0);
    check("wrst_a_cleared", 32'(bus.fpu_a), 32'h0);
    tick();
    check("wrst_ready", 32'(bus.ready), 32'h1);
    bus.fpu_done   = 1'b1;
    bus.fpu_result = 16'h1234;
    tick();
    bus.fpu_done = 1'b0;
    check_beat("wrst_late_done", 2'b00, 8'h00);
    check("wrst_ready2", 32'(bus.ready), 32'h1);
    tick();
    check("wrst_no_beats", 32'(beat_cnt - b0), 32'h0);
    check("no_abort", 32'(abort_cnt), 32'h0);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Core never answers: abort after the 8th WAIT cycle
    drive(2'b11, 8'h01);
    tick();
    drive(2'b00, 8'h00);
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_wait_abort", 32'(bus.fpu_abort), 32'h0);
      check("to_wait_tag", 32'(bus.out_tag), 32'h0);
    end
    tick();
    check("to_abort", 32'(bus.fpu_abort), 32'h1);
    check_beat("to_err", 2'b11, 8'hFF);
    bus.fpu_done = 1'b1;
    tick();
    bus.fpu_done = 1'b0;
    check("to_abort_pulse", 32'(bus.fpu_abort), 32'h0);
    check("to_ready", 32'(bus.ready), 32'h1);
    check_beat("to_idle", 2'b00, 8'h00);
    tick();
    check_beat("to_late_done", 2'b00, 8'h00);
    check("to_abort_cnt", 32'(abort_cnt), 32'h1);

    // Done on the limit cycle wins over the timeout
    run_op("to_race", 8'h04, 4'h4, 16'h0000, 16'h0000, 8, 16'hBEEF, 5'b00001, 1'b0);
    check("to_race_abort_cnt", 32'(abort_cnt), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
